mem_bus_arbiter: RTL and testbench

- Arbitrates the SoC data RAM (16-bit word, split high/low byte lanes) between two requesters.
- M0 is the CPU load/store strobe port (LW/LB/SW/SB); M1 is a secondary valid/ready master (DMA / UART debug loader).
- The block translates byte addresses into a word index plus lane write-enables, routes one-cycle-latency read data back to the issuing master, and stalls the loser.
- CPU has fixed priority, with a bounded-wait guarantee for M1.

---
 rtl/mem_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Data RAM arbiter: CPU strobe port (M0) has fixed priority over a valid/ready master (M1),
// with a bounded-wait grant for M1. Optional stall statistics behind MEM_ARB_STATS_EN.
module mem_bus_arbiter #(
   parameter int unsigned AW       = 9,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_m0_lw,
   input  logic          i_m0_lb,
   input  logic          i_m0_sw,
   input  logic          i_m0_sb,
   input  logic [15:0]   i_m0_ad,
   input  logic [15:0]   i_m0_do,
   output logic [15:0]   o_m0_di,
   output logic          o_m0_stall,
   input  logic          i_m1_req,
   input  logic          i_m1_we,
   input  logic          i_m1_byte,
   input  logic [15:0]   i_m1_ad,
   input  logic [15:0]   i_m1_wdata,
   output logic          o_m1_gnt,
   output logic          o_m1_rvalid,
   output logic [15:0]   o_m1_rdata,
   output logic [AW-1:0] o_mem_ad,
   output logic [15:0]   o_mem_wd,
   output logic          o_mem_we_h,
   output logic          o_mem_we_l,
   output logic          o_mem_re,
   input  logic [15:0]   i_mem_rd
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]   o_m1_wait_total
`endif
);

   typedef enum logic [1:0] {
      OwnNone,
      OwnM0,
      OwnM1
   } owner_e;

   localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

   logic [3:0]  wait_q, wait_d;
   owner_e      rd_owner_q, rd_owner_d;
   logic        rd_byte_q, rd_byte_d;
   logic        rd_lane_q, rd_lane_d;
   logic [15:0] m0_di_q, m0_di_d;
   logic [15:0] m1_rdata_q, m1_rdata_d;
   logic        m1_rvalid_q, m1_rvalid_d;

   logic        m0_active, m0_we, m0_byte;
   logic        force_m1, m1_win, m0_win, issue;
   logic        sel_we, sel_byte;
   logic [15:0] sel_ad, sel_wd;
   logic [15:0] rd_data;
   logic        unused_ad_hi;

   // M0 strobe priority SW > SB > LW > LB collapses to a write flag plus a byte flag.
   always_comb begin
      m0_active = i_m0_sw | i_m0_sb | i_m0_lw | i_m0_lb;
      m0_we     = i_m0_sw | i_m0_sb;
      m0_byte   = ~i_m0_sw & (i_m0_sb | (~i_m0_lw & i_m0_lb));
   end

   always_comb begin
      force_m1 = i_m1_req && (MaxWait != 4'd0) && (wait_q == MaxWait);
      m1_win   = force_m1 || (i_m1_req && !m0_active);
      m0_win   = m0_active && !m1_win;
      issue    = (m0_win || m1_win) && i_rst_n;
   end

   // With no request the M0 fields stay on the bus; enables are what matter.
   always_comb begin
      sel_we   = m0_we;
      sel_byte = m0_byte;
      sel_ad   = i_m0_ad;
      sel_wd   = i_m0_do;
      if (m1_win) begin
         sel_we   = i_m1_we;
         sel_byte = i_m1_byte;
         sel_ad   = i_m1_ad;
         sel_wd   = i_m1_wdata;
      end
   end

   always_comb begin
      o_mem_ad   = sel_ad[AW:1];
      o_mem_wd   = sel_byte ? {sel_wd[7:0], sel_wd[7:0]} : sel_wd;
      o_mem_we_h = issue & sel_we & (~sel_byte | sel_ad[0]);
      o_mem_we_l = issue & sel_we & (~sel_byte | ~sel_ad[0]);
      o_mem_re   = issue & ~sel_we;
      o_m1_gnt   = m1_win & i_rst_n;
      o_m0_stall = m0_active & m1_win & i_rst_n;
   end

   assign unused_ad_hi = ^sel_ad[15:AW+1];

   always_comb begin
      wait_d = wait_q;
      if (!i_m1_req || m1_win) begin
         wait_d = 4'd0;
      end else if (wait_q < MaxWait) begin
         wait_d = wait_q + 4'd1;
      end
   end

   always_comb begin
      rd_owner_d = OwnNone;
      if (o_mem_re) begin
         rd_owner_d = m1_win ? OwnM1 : OwnM0;
      end
      rd_byte_d = sel_byte;
      rd_lane_d = sel_ad[0];
   end

   // Return path: RAM data arrives one cycle after issue and is captured into the owner's register.
   always_comb begin
      rd_data     = rd_byte_q ? {8'h00, (rd_lane_q ? i_mem_rd[15:8] : i_mem_rd[7:0])} : i_mem_rd;
      m0_di_d     = (rd_owner_q == OwnM0) ? rd_data : m0_di_q;
      m1_rdata_d  = (rd_owner_q == OwnM1) ? rd_data : m1_rdata_q;
      m1_rvalid_d = (rd_owner_q == OwnM1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_q      <= 4'd0;
         rd_owner_q  <= OwnNone;
         rd_byte_q   <= 1'b0;
         rd_lane_q   <= 1'b0;
         m0_di_q     <= 16'h0000;
         m1_rdata_q  <= 16'h0000;
         m1_rvalid_q <= 1'b0;
      end else begin
         wait_q      <= wait_d;
         rd_owner_q  <= rd_owner_d;
         rd_byte_q   <= rd_byte_d;
         rd_lane_q   <= rd_lane_d;
         m0_di_q     <= m0_di_d;
         m1_rdata_q  <= m1_rdata_d;
         m1_rvalid_q <= m1_rvalid_d;
      end
   end

   assign o_m0_di     = m0_di_q;
   assign o_m1_rdata  = m1_rdata_q;
   assign o_m1_rvalid = m1_rvalid_q;

`ifdef MEM_ARB_STATS_EN
   logic [15:0] wait_total_q, wait_total_d;

   always_comb begin
      wait_total_d = wait_total_q;
      if (i_m1_req && !o_m1_gnt && (wait_total_q != 16'hFFFF)) begin
         wait_total_d = wait_total_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_total_q <= 16'h0000;
      end else begin
         wait_total_q <= wait_total_d;
      end
   end

   assign o_m1_wait_total = wait_total_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: byte-array reference memory, directed plus random traffic.
module tb_mem_bus_arbiter;

   localparam int unsigned AW       = 9;
   localparam int unsigned MAX_WAIT = 4;
   localparam int          DEPTH    = 1 << AW;

   typedef struct {
      logic        sw, sb, lw, lb;
      logic [15:0] m0ad, m0do;
      logic        m1req, m1we, m1byte;
      logic [15:0] m1ad, m1wd;
   } stim_t;

   typedef struct {
      int          due;
      logic [15:0] val;
   } resp_t;

   logic          clk;
   logic          rst_n;
   logic          m0_lw, m0_lb, m0_sw, m0_sb;
   logic [15:0]   m0_ad, m0_do, m0_di;
   logic          m0_stall;
   logic          m1_req, m1_we, m1_byte;
   logic [15:0]   m1_ad, m1_wdata, m1_rdata;
   logic          m1_gnt, m1_rvalid;
   logic [AW-1:0] mem_ad;
   logic [15:0]   mem_wd, mem_rd;
   logic          mem_we_h, mem_we_l, mem_re;
   logic [15:0]   wait_total;

   mem_bus_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_m0_lw     (m0_lw),
      .i_m0_lb     (m0_lb),
      .i_m0_sw     (m0_sw),
      .i_m0_sb     (m0_sb),
      .i_m0_ad     (m0_ad),
      .i_m0_do     (m0_do),
      .o_m0_di     (m0_di),
      .o_m0_stall  (m0_stall),
      .i_m1_req    (m1_req),
      .i_m1_we     (m1_we),
      .i_m1_byte   (m1_byte),
      .i_m1_ad     (m1_ad),
      .i_m1_wdata  (m1_wdata),
      .o_m1_gnt    (m1_gnt),
      .o_m1_rvalid (m1_rvalid),
      .o_m1_rdata  (m1_rdata),
      .o_mem_ad    (mem_ad),
      .o_mem_wd    (mem_wd),
      .o_mem_we_h  (mem_we_h),
      .o_mem_we_l  (mem_we_l),
      .o_mem_re    (mem_re),
      .i_mem_rd    (mem_rd)
`ifdef MEM_ARB_STATS_EN
      ,
      .o_m1_wait_total (wait_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Environment RAM: one-cycle read latency, byte-lane writes.
   logic [15:0] ram [DEPTH];
   logic [15:0] rd_q;
   always @(posedge clk) begin
      if (mem_we_h) ram[mem_ad][15:8] <= mem_wd[15:8];
      if (mem_we_l) ram[mem_ad][7:0] <= mem_wd[7:0];
      if (mem_re) rd_q <= ram[mem_ad];
   end
   assign mem_rd = rd_q;

   // Reference state
   logic [7:0]  ref_mem [2*DEPTH];
   int          lost;
   logic [15:0] exp_wt;
   resp_t       m0_q[$];
   resp_t       m1_q[$];
   logic        exp_gnt, exp_stall, exp_re, exp_we_h, exp_we_l, exp_issue, exp_wr;
   logic [15:0] exp_ad, exp_wd;
   logic        rst_next;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic stim_t st_idle();
      stim_t s;
      s = '{sw: 0, sb: 0, lw: 0, lb: 0, m0ad: 16'h0, m0do: 16'h0,
            m1req: 0, m1we: 0, m1byte: 0, m1ad: 16'h0, m1wd: 16'h0};
      return s;
   endfunction

   // str = {sw, sb, lw, lb}
   function automatic stim_t st_m0(input logic [3:0] str, input logic [15:0] ad, input logic [15:0] d);
      stim_t s;
      s = st_idle();
      {s.sw, s.sb, s.lw, s.lb} = str;
      s.m0ad = ad;
      s.m0do = d;
      return s;
   endfunction

   function automatic stim_t st_m1(input logic we, input logic byt, input logic [15:0] ad,
                                   input logic [15:0] d);
      stim_t s;
      s = st_idle();
      s.m1req  = 1'b1;
      s.m1we   = we;
      s.m1byte = byt;
      s.m1ad   = ad;
      s.m1wd   = d;
      return s;
   endfunction

   // Apply one cycle of stimulus and predict its effect from the arbitration rules.
   task automatic drive(input stim_t s);
      logic        m0act, m1_go, m0_go, w, b, to_m1;
      logic [15:0] a, d, val;
      int          idx, base;
      @(posedge clk);
      #1;
      rst_n    = rst_next;
      m0_sw    = s.sw;
      m0_sb    = s.sb;
      m0_lw    = s.lw;
      m0_lb    = s.lb;
      m0_ad    = s.m0ad;
      m0_do    = s.m0do;
      m1_req   = s.m1req;
      m1_we    = s.m1we;
      m1_byte  = s.m1byte;
      m1_ad    = s.m1ad;
      m1_wdata = s.m1wd;
      {exp_gnt, exp_stall, exp_re, exp_we_h, exp_we_l, exp_issue, exp_wr} = '0;
      exp_ad = '0;
      exp_wd = '0;
      if (!rst_n) begin
         m0_q.delete();
         m1_q.delete();
         lost   = 0;
         exp_wt = '0;
         return;
      end
      m0act = s.sw | s.sb | s.lw | s.lb;
      if (s.m1req && MAX_WAIT != 0 && lost == MAX_WAIT) m1_go = 1'b1;
      else if (m0act) m1_go = 1'b0;
      else m1_go = s.m1req;
      m0_go = m0act && !m1_go;
      if (s.m1req && !m1_go) begin
         lost = (lost < MAX_WAIT) ? lost + 1 : lost;
         if (exp_wt != 16'hFFFF) exp_wt = exp_wt + 16'd1;
      end else begin
         lost = 0;
      end
      exp_gnt   = m1_go;
      exp_stall = m0act && m1_go;
      if (!(m1_go || m0_go)) return;
      exp_issue = 1'b1;
      if (m1_go) begin
         w = s.m1we; b = s.m1byte; a = s.m1ad; d = s.m1wd; to_m1 = 1'b1;
      end else begin
         to_m1 = 1'b0; a = s.m0ad; d = s.m0do;
         if (s.sw) begin w = 1; b = 0; end
         else if (s.sb) begin w = 1; b = 1; end
         else if (s.lw) begin w = 0; b = 0; end
         else begin w = 0; b = 1; end
      end
      idx    = int'(a) % (2 * DEPTH);
      base   = idx - (idx % 2);
      exp_ad = 16'(idx / 2);
      exp_wr = w;
      if (w) begin
         if (b) begin
            ref_mem[idx] = d[7:0];
            exp_we_h = (idx % 2) == 1;
            exp_we_l = (idx % 2) == 0;
            exp_wd   = {d[7:0], d[7:0]};
         end else begin
            ref_mem[base]     = d[7:0];
            ref_mem[base + 1] = d[15:8];
            exp_we_h = 1'b1;
            exp_we_l = 1'b1;
            exp_wd   = d;
         end
      end else begin
         exp_re = 1'b1;
         val = b ? {8'h00, ref_mem[idx]} : {ref_mem[base + 1], ref_mem[base]};
         if (to_m1) m1_q.push_back('{due: cyc + 2, val: val});
         else m0_q.push_back('{due: cyc + 2, val: val});
      end
   endtask

   // Monitor: compares combinational controls each cycle and pops read responses when due.
   always @(negedge clk) begin
      logic due1;
      chk("ctl{gnt,stall,re,we_h,we_l}", {27'd0, m1_gnt, m0_stall, mem_re, mem_we_h, mem_we_l},
          {27'd0, exp_gnt, exp_stall, exp_re, exp_we_h, exp_we_l});
      if (exp_issue) chk("mem_ad", 32'(mem_ad), 32'(exp_ad));
      if (exp_issue && exp_wr) chk("mem_wd", 32'(mem_wd), 32'(exp_wd));
      due1 = (m1_q.size() > 0) && (m1_q[0].due == cyc);
      chk("m1_rvalid", 32'(m1_rvalid), 32'(due1));
      if (due1) begin
         chk("m1_rdata", 32'(m1_rdata), 32'(m1_q[0].val));
         void'(m1_q.pop_front());
      end
      if ((m0_q.size() > 0) && (m0_q[0].due == cyc)) begin
         chk("m0_di", 32'(m0_di), 32'(m0_q[0].val));
         void'(m0_q.pop_front());
      end
   end

   initial begin
      stim_t s;
      for (int i = 0; i < DEPTH; i++) ram[i] = 16'h0000;
      for (int i = 0; i < 2 * DEPTH; i++) ref_mem[i] = 8'h00;
      rd_q = 16'h0000;
      lost = 0;
      exp_wt = '0;
      {exp_gnt, exp_stall, exp_re, exp_we_h, exp_we_l, exp_issue, exp_wr} = '0;
      exp_ad = '0;
      exp_wd = '0;
      rst_n = 1'b0;
      rst_next = 1'b0;
      {m0_sw, m0_sb, m0_lw, m0_lb, m1_req, m1_we, m1_byte} = '0;
      {m0_ad, m0_do, m1_ad, m1_wdata} = '0;

      drive(st_m1(1'b0, 1'b0, 16'h0008, 16'h0));  // request during reset must be masked
      @(negedge clk);
      chk("rst_m0_di", 32'(m0_di), 32'h0);
      chk("rst_m1_rdata", 32'(m1_rdata), 32'h0);
      chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
      rst_next = 1'b1;
      drive(st_idle());

      // Word store then load
      drive(st_m0(4'b1000, 16'h0006, 16'hCAFE));
      drive(st_m0(4'b0010, 16'h0006, 16'h0));
      drive(st_idle());
      drive(st_idle());
      @(negedge clk);
      chk("lw_cafe", 32'(m0_di), 32'hCAFE);

      // Byte store into high lane, byte and word loads
      drive(st_m0(4'b0100, 16'h0007, 16'h00A5));
      drive(st_m0(4'b0001, 16'h0007, 16'h0));
      drive(st_m0(4'b0010, 16'h0006, 16'h0));
      drive(st_idle());
      drive(st_idle());
      @(negedge clk);
      chk("lw_a5fe", 32'(m0_di), 32'hA5FE);

      // M1 write and read while M0 idle
      drive(st_m1(1'b1, 1'b0, 16'h0008, 16'h1357));
      drive(st_m1(1'b0, 1'b0, 16'h0008, 16'h0));
      drive(st_idle());
      drive(st_idle());
      @(negedge clk);
      chk("m1_rd_1357", 32'(m1_rdata), 32'h1357);
      chk("m0_di_hold", 32'(m0_di), 32'hA5FE);

      // Bounded wait: M1 forced on the 5th contended cycle, again 5 cycles later
      for (int i = 0; i < 10; i++) begin
         s = st_m0(4'b0010, 16'h0006, 16'h0);
         s.m1req = 1'b1;
         s.m1ad  = 16'h0008;
         drive(s);
         @(negedge clk);
         chk("bounded_gnt", 32'(m1_gnt), 32'((i == 4) || (i == 9)));
      end
      drive(st_idle());
      drive(st_idle());

      // Simultaneous SW and LW: store wins, no read issued
      drive(st_m0(4'b1010, 16'h0010, 16'hBEEF));
      @(negedge clk);
      chk("sw_lw_no_re", 32'(mem_re), 32'h0);
      drive(st_idle());
      drive(st_idle());
      @(negedge clk);
      chk("sw_lw_di_hold", 32'(m0_di), 32'hA5FE);

      // Reset the cycle after an M1 read issue
      drive(st_m1(1'b0, 1'b0, 16'h0008, 16'h0));
      rst_next = 1'b0;
      drive(st_idle());
      @(negedge clk);
      chk("rst2_m0_di", 32'(m0_di), 32'h0);
      chk("rst2_m1_rdata", 32'(m1_rdata), 32'h0);
      drive(st_idle());
      rst_next = 1'b1;
      drive(st_m0(4'b0010, 16'h0010, 16'h0));
      drive(st_idle());
      drive(st_idle());
      @(negedge clk);
      chk("post_rst_lw", 32'(m0_di), 32'hBEEF);

      // Random traffic over a small address window to force collisions
      for (int i = 0; i < 600; i++) begin
         s = st_idle();
         s.sw     = ($urandom_range(0, 7) == 0);
         s.sb     = ($urandom_range(0, 7) == 0);
         s.lw     = ($urandom_range(0, 3) == 0);
         s.lb     = ($urandom_range(0, 3) == 0);
         s.m0ad   = {$urandom_range(0, 15) << 12} | 16'($urandom_range(0, 63));
         s.m0do   = 16'($urandom);
         s.m1req  = ($urandom_range(0, 1) == 1);
         s.m1we   = ($urandom_range(0, 2) == 0);
         s.m1byte = ($urandom_range(0, 1) == 1);
         s.m1ad   = {$urandom_range(0, 15) << 12} | 16'($urandom_range(0, 63));
         s.m1wd   = 16'($urandom);
         drive(s);
      end
      for (int i = 0; i < 4; i++) drive(st_idle());
      @(negedge clk);
      chk("m0_q_drained", 32'(m0_q.size()), 32'h0);
      chk("m1_q_drained", 32'(m1_q.size()), 32'h0);
`ifdef MEM_ARB_STATS_EN
      chk("wait_total", 32'(wait_total), 32'(exp_wt));
`else
      wait_total = exp_wt;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
